mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin memory bus arbiter (port 0 = CPU, port 1 = DMA/debug).
// A single access is in flight at a time: IDLE -> ACCESS -> DONE, with a turnaround idle cycle after every completion.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              we_0,
    input  logic              we_1,
    input  logic [1:0]        size_0,
    input  logic [1:0]        size_1,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              ack_0,
    output logic              ack_1,
    output logic              err_0,
    output logic              err_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              cpu_enable
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    logic                r_last;
    logic                r_gnt;
    logic                r_turn;
    logic [7:0]          r_wait;
    logic [1:0]          r_ack;
    logic [1:0]          r_err;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [1:0]          r_mem_size;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_rdata_0;
    logic [DATA_W-1:0]   r_rdata_1;

    logic                w_any;
    logic                w_win;
    logic                w_we;
    logic [1:0]          w_size;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;

    // On a tie the port that was not granted last wins; a lone requester always wins.
    assign w_any   = req_0 | req_1;
    assign w_win   = (req_0 & req_1) ? ~r_last : req_1;
    assign w_we    = w_win ? we_1    : we_0;
    assign w_size  = w_win ? size_1  : size_0;
    assign w_addr  = w_win ? addr_1  : addr_0;
    assign w_wdata = w_win ? wdata_1 : wdata_0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_gnt       <= 1'b0;
            r_turn      <= 1'b0;
            r_wait      <= 8'd0;
            r_ack       <= 2'b00;
            r_err       <= 2'b00;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_size  <= 2'b00;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata_0   <= '0;
            r_rdata_1   <= '0;
        end else begin
            r_ack <= 2'b00;
            r_err <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (r_turn) begin
                        r_turn <= 1'b0;
                    end else if (w_any) begin
                        r_last <= w_win;
                        r_gnt  <= w_win;
                        if (w_size == 2'b11) begin
                            r_err[w_win] <= 1'b1;
                            r_turn       <= 1'b1;
                        end else begin
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= w_we;
                            r_mem_size  <= w_size;
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_wdata;
                            r_wait      <= 8'd0;
                            r_state     <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_ready) begin
                        if (!r_mem_we) begin
                            if (r_gnt) r_rdata_1 <= mem_rdata;
                            else       r_rdata_0 <= mem_rdata;
                        end
                        r_ack[r_gnt] <= 1'b1;
                        r_mem_en     <= 1'b0;
                        r_state      <= S_DONE;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                        // Timeout exits straight to IDLE; the turnaround flag still blocks an immediate regrant.
                        if (r_wait == LP_WAIT_LAST) begin
                            r_err[r_gnt] <= 1'b1;
                            r_mem_en     <= 1'b0;
                            r_turn       <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    r_turn  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack_0      = r_ack[0];
    assign ack_1      = r_ack[1];
    assign err_0      = r_err[0];
    assign err_1      = r_err[1];
    assign rdata_0    = r_rdata_0;
    assign rdata_1    = r_rdata_1;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_size   = r_mem_size;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_enable = ~(req_0 & ~r_ack[0]);

endmodule
